// File: rtl/uart_io_pkg.sv
// Shared constants for the UART Lite sequencer:
// register map, status bits, FSM and engine states.
package uart_io_pkg;

  typedef enum logic [3:0] {
    RA_RX_FIFO = 4'h0,
    RA_STAT    = 4'h8
  } raddr_e;

  typedef enum logic [3:0] {
    WA_TX_FIFO = 4'h4,
    WA_CTRL    = 4'hC
  } waddr_e;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_TX_FULL  = 3;

  localparam logic [31:0] CTRL_INIT = 32'h0000_0003;

  localparam logic LG_RX = 1'b0;
  localparam logic LG_TX = 1'b1;

  localparam logic [3:0] S_INIT_AW = 4'd0;
  localparam logic [3:0] S_INIT_B  = 4'd1;
  localparam logic [3:0] S_IDLE    = 4'd2;
  localparam logic [3:0] S_STAT_AR = 4'd3;
  localparam logic [3:0] S_STAT_R  = 4'd4;
  localparam logic [3:0] S_TX_AW   = 4'd5;
  localparam logic [3:0] S_TX_B    = 4'd6;
  localparam logic [3:0] S_RX_AR   = 4'd7;
  localparam logic [3:0] S_RX_R    = 4'd8;
  localparam logic [3:0] S_RX_HOLD = 4'd9;

  localparam logic [1:0] P_IDLE = 2'd0;
  localparam logic [1:0] P_ADDR = 2'd1;
  localparam logic [1:0] P_RESP = 2'd2;

endpackage

// File: rtl/axil_single_xfer.sv
// One-outstanding AXI4-lite read/write engine.
// Registered channel outputs; done/acc are same-cycle.
module axil_single_xfer
  import uart_io_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        wr,
  input  logic [3:0]  addr,
  input  logic [31:0] data,
  input  logic [3:0]  strb,
  output logic        idle,
  output logic        acc,
  output logic        done,
  output logic [7:0]  rdata,
  output logic [1:0]  resp,
  output logic [3:0]  uart_axi_araddr,
  output logic        uart_axi_arvalid,
  input  logic        uart_axi_arready,
  input  logic [31:0] uart_axi_rdata,
  input  logic        uart_axi_rvalid,
  output logic        uart_axi_rready,
  input  logic [1:0]  uart_axi_rresp,
  output logic [3:0]  uart_axi_awaddr,
  output logic        uart_axi_awvalid,
  input  logic        uart_axi_awready,
  output logic [31:0] uart_axi_wdata,
  output logic [3:0]  uart_axi_wstrb,
  output logic        uart_axi_wvalid,
  input  logic        uart_axi_wready,
  input  logic        uart_axi_bvalid,
  output logic        uart_axi_bready,
  input  logic [1:0]  uart_axi_bresp
);

  logic [1:0] ph;
  logic       is_wr;
  logic       aw_ok;
  logic       w_ok;
  logic       unused_rdata;

  assign unused_rdata = ^uart_axi_rdata[31:8];

  assign aw_ok = !uart_axi_awvalid || uart_axi_awready;
  assign w_ok  = !uart_axi_wvalid || uart_axi_wready;

  assign idle = (ph == P_IDLE);
  assign acc  = (ph == P_ADDR) &&
                (is_wr ? (aw_ok && w_ok)
                       : (uart_axi_arvalid && uart_axi_arready));
  assign done = (ph == P_RESP) &&
                (is_wr ? (uart_axi_bvalid && uart_axi_bready)
                       : (uart_axi_rvalid && uart_axi_rready));
  assign rdata = uart_axi_rdata[7:0];
  assign resp  = is_wr ? uart_axi_bresp : uart_axi_rresp;

  // Phase sequencing; a new start may overlap the response beat
  always_ff @(posedge clk) begin
    if (rst) begin
      ph               <= P_IDLE;
      is_wr            <= 1'b0;
      uart_axi_araddr  <= RA_STAT;
      uart_axi_arvalid <= 1'b0;
      uart_axi_rready  <= 1'b0;
      uart_axi_awaddr  <= WA_CTRL;
      uart_axi_awvalid <= 1'b0;
      uart_axi_wdata   <= 32'h0;
      uart_axi_wstrb   <= 4'h0;
      uart_axi_wvalid  <= 1'b0;
      uart_axi_bready  <= 1'b0;
    end else begin
      case (ph)
        P_ADDR: begin
          if (is_wr) begin
            if (uart_axi_awvalid && uart_axi_awready)
              uart_axi_awvalid <= 1'b0;
            if (uart_axi_wvalid && uart_axi_wready)
              uart_axi_wvalid <= 1'b0;
            if (acc) begin
              uart_axi_bready <= 1'b1;
              ph              <= P_RESP;
            end
          end else if (acc) begin
            uart_axi_arvalid <= 1'b0;
            uart_axi_rready  <= 1'b1;
            ph               <= P_RESP;
          end
        end
        P_RESP: begin
          if (done) begin
            uart_axi_rready <= 1'b0;
            uart_axi_bready <= 1'b0;
            ph              <= P_IDLE;
          end
        end
        default: ;
      endcase
      if (start && (idle || done)) begin
        ph    <= P_ADDR;
        is_wr <= wr;
        if (wr) begin
          uart_axi_awaddr  <= addr;
          uart_axi_wdata   <= data;
          uart_axi_wstrb   <= strb;
          uart_axi_awvalid <= 1'b1;
          uart_axi_wvalid  <= 1'b1;
        end else begin
          uart_axi_araddr  <= addr;
          uart_axi_arvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_io_ctrl.sv
// UART Lite sequencer: round-robin TX/RX service,
// each as a STAT poll followed by a FIFO access.
module uart_io_ctrl
  import uart_io_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  input  logic        rx_en,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        busy,
  output logic        err,
  output logic [3:0]  uart_axi_araddr,
  output logic        uart_axi_arvalid,
  input  logic        uart_axi_arready,
  input  logic [31:0] uart_axi_rdata,
  input  logic        uart_axi_rvalid,
  output logic        uart_axi_rready,
  input  logic [1:0]  uart_axi_rresp,
  output logic [3:0]  uart_axi_awaddr,
  output logic        uart_axi_awvalid,
  input  logic        uart_axi_awready,
  output logic [31:0] uart_axi_wdata,
  output logic [3:0]  uart_axi_wstrb,
  output logic        uart_axi_wvalid,
  input  logic        uart_axi_wready,
  input  logic        uart_axi_bvalid,
  output logic        uart_axi_bready,
  input  logic [1:0]  uart_axi_bresp
);

  logic [3:0]  state;
  logic [7:0]  tx_hold;
  logic        tx_held;
  logic        last_gnt;
  logic        gnt_tx;
  logic        tx_pend;
  logic        rx_pend;
  logic        pick_tx;
  logic        pick_rx;
  logic        start;
  logic        wr;
  logic [3:0]  addr;
  logic [31:0] data;
  logic [3:0]  strb;
  logic        eng_idle;
  logic        acc;
  logic        done;
  logic [7:0]  rdata;
  logic [1:0]  resp;

  assign tx_pend = tx_valid || tx_held;
  assign rx_pend = rx_en && !rx_valid;
  assign pick_tx = tx_pend && (!rx_pend || last_gnt == LG_RX);
  assign pick_rx = rx_pend && !pick_tx;

  assign busy     = (state != S_IDLE);
  assign tx_ready = !rst && state == S_IDLE &&
                    pick_tx && !tx_held;

  // Which transaction to launch on the engine this cycle
  always_comb begin
    start = 1'b0;
    wr    = 1'b0;
    addr  = RA_STAT;
    data  = 32'h0;
    strb  = 4'h0;
    case (state)
      S_INIT_AW: begin
        start = eng_idle;
        wr    = 1'b1;
        addr  = WA_CTRL;
        data  = CTRL_INIT;
        strb  = 4'hF;
      end
      S_IDLE: start = pick_tx || pick_rx;
      S_STAT_R: begin
        if (done && gnt_tx && !rdata[STAT_TX_FULL]) begin
          start = 1'b1;
          wr    = 1'b1;
          addr  = WA_TX_FIFO;
          data  = {24'h0, tx_hold};
          strb  = 4'h1;
        end
        if (done && !gnt_tx && rdata[STAT_RX_VALID]) begin
          start = 1'b1;
          addr  = RA_RX_FIFO;
        end
      end
      default: ;
    endcase
  end

  // Sequencer state, held TX byte, RX byte and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT_AW;
      tx_hold  <= 8'h0;
      tx_held  <= 1'b0;
      last_gnt <= LG_RX;
      gnt_tx   <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h0;
      err      <= 1'b0;
    end else begin
      if (done && resp != 2'b00)
        err <= 1'b1;
      case (state)
        S_INIT_AW: if (acc) state <= S_INIT_B;
        S_INIT_B:  if (done) state <= S_IDLE;
        S_IDLE: begin
          if (pick_tx || pick_rx) begin
            gnt_tx <= pick_tx;
            state  <= S_STAT_AR;
          end
          if (pick_tx && !tx_held) begin
            tx_hold <= tx_data;
            tx_held <= 1'b1;
          end
        end
        S_STAT_AR: if (acc) state <= S_STAT_R;
        S_STAT_R: begin
          if (done) begin
            if (gnt_tx)
              state <= rdata[STAT_TX_FULL] ? S_IDLE : S_TX_AW;
            else
              state <= rdata[STAT_RX_VALID] ? S_RX_AR : S_IDLE;
          end
        end
        S_TX_AW: if (acc) state <= S_TX_B;
        S_TX_B: begin
          if (done) begin
            tx_held  <= 1'b0;
            last_gnt <= LG_TX;
            state    <= S_IDLE;
          end
        end
        S_RX_AR: if (acc) state <= S_RX_R;
        S_RX_R: begin
          if (done) begin
            rx_data  <= rdata;
            rx_valid <= 1'b1;
            last_gnt <= LG_RX;
            state    <= S_RX_HOLD;
          end
        end
        S_RX_HOLD: begin
          if (rx_ready) begin
            rx_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_INIT_AW;
      endcase
    end
  end

  axil_single_xfer u_xfer (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .wr               (wr),
    .addr             (addr),
    .data             (data),
    .strb             (strb),
    .idle             (eng_idle),
    .acc              (acc),
    .done             (done),
    .rdata            (rdata),
    .resp             (resp),
    .uart_axi_araddr  (uart_axi_araddr),
    .uart_axi_arvalid (uart_axi_arvalid),
    .uart_axi_arready (uart_axi_arready),
    .uart_axi_rdata   (uart_axi_rdata),
    .uart_axi_rvalid  (uart_axi_rvalid),
    .uart_axi_rready  (uart_axi_rready),
    .uart_axi_rresp   (uart_axi_rresp),
    .uart_axi_awaddr  (uart_axi_awaddr),
    .uart_axi_awvalid (uart_axi_awvalid),
    .uart_axi_awready (uart_axi_awready),
    .uart_axi_wdata   (uart_axi_wdata),
    .uart_axi_wstrb   (uart_axi_wstrb),
    .uart_axi_wvalid  (uart_axi_wvalid),
    .uart_axi_wready  (uart_axi_wready),
    .uart_axi_bvalid  (uart_axi_bvalid),
    .uart_axi_bready  (uart_axi_bready),
    .uart_axi_bresp   (uart_axi_bresp)
  );

endmodule

// File: doc/uart_io_ctrl.md
# uart_io_ctrl

Sequencer and arbiter for the AXI4-lite UART Lite core. It accepts byte-send requests from a TX requester and byte-receive service for an RX requester, and arbitrates between them round-robin. Each transfer is performed as a status poll followed by a FIFO read or write. It replaces the ad-hoc STAT_REG polling previously done in the CPU and loader state machines and is the only master on the UART AXI4-lite port.

## Interface
- No parameters; register map fixed: RX_FIFO 0x0, TX_FIFO 0x4, STAT_REG 0x8, CTRL_REG 0xC.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- tx_valid  in  1  TX requester has a byte.
- tx_data  in  8  byte to send.
- tx_ready  out  1  one-cycle accept pulse; byte captured that cycle.
- rx_en  in  1  RX requester wants bytes; while low, RX FIFO is not read.
- rx_valid  out  1  received byte available; held until rx_ready.
- rx_data  out  8  received byte.
- rx_ready  in  1  RX requester consumes byte.
- busy  out  1  high whenever FSM is not IDLE.
- err  out  1  sticky; set on any rresp/bresp ≠ 0, cleared only by rst.
- uart_axi_ar*/r*/aw*/w*/b*: full AXI4-lite master: araddr[3:0], arvalid, arready, rdata[31:0], rvalid, rready, rresp[1:0], awaddr[3:0], awvalid, awready, wdata[31:0], wstrb[3:0], wvalid, wready, bvalid, bready, bresp[1:0].

## Operation
- States: INIT_AW, INIT_B, IDLE, STAT_AR, STAT_R, TX_AW, TX_B, RX_AR, RX_R, RX_HOLD.
- After reset: INIT_AW writes 0x3 to CTRL_REG (reset both FIFOs), INIT_B waits for bvalid, then IDLE.
- IDLE arbitration: tx pending = tx_valid or held byte (tx_hold); rx pending = rx_en. If both, grant the side not served last (last_gnt flag, reset value RX so TX wins first). On TX grant without a held byte: tx_ready=1, capture tx_data into tx_hold. Go to STAT_AR.
- STAT_AR: araddr=0x8, arvalid=1 until arready. STAT_R: rready=1 until rvalid; latch rdata.
- Decision on status: TX grant and bit3 (TX full)=0 → TX_AW; TX grant and full → IDLE, byte stays in tx_hold and the TX side remains pending. RX grant and bit0 (RX valid)=1 → RX_AR; otherwise → IDLE. last_gnt updates only when a transfer completes.
- TX_AW: awaddr=0x4, wdata={24'b0, tx_hold}, wstrb=4'b0001. awvalid and wvalid rise together; each drops independently on its own handshake. Leave the state when both are done. TX_B: bready=1 until bvalid; clear tx_hold; → IDLE.
- RX_AR: araddr=0x0 handshake. RX_R: on rvalid, rx_data=rdata[7:0], rx_valid=1 → RX_HOLD. RX_HOLD: wait for rx_ready, then drop rx_valid → IDLE. No new RX read while rx_valid is high.
- err sets on the handshake cycle of any response with nonzero resp. The transaction still completes normally.

## Timing
- Reset values: all *valid 0, rready 0, bready 0, araddr 0x8, awaddr 0xC, wdata 0, wstrb 0, tx_ready 0, rx_valid 0, rx_data 0, err 0, busy 1 (INIT).
- Best-case TX, slave always ready: tx_ready in cycle 0 (IDLE), arvalid in cycle 1, rready in cycle 2, aw/wvalid in cycle 3, bready in cycle 4, IDLE in cycle 5.
- Best-case RX: rx_valid rises 5 cycles after IDLE grant.
- Valids never drop before their handshake. Addresses and data are stable while valid.
- rst mid-transaction: all valids and readies drop the next cycle; tx_hold and rx byte are discarded; INIT is rerun.

## Structure
- uart_io_pkg: register-address enums (raddr/waddr), STAT bit indices (RX_VALID=0, TX_FULL=3), CTRL reset value 0x3, state enum.
- One sub-module: axil_single_xfer, a one-outstanding read/write engine (start, write flag, addr, wdata → done, rdata, resp). The FSM drives it for every transaction.

## Test plan
- Reset, slave ready: CTRL_REG write of 0x00000003 occurs first; busy falls after bvalid; err=0.
- tx_valid with 0x41, STAT=0x00: tx_ready pulse at cycle 0, wdata 0x00000041 at awaddr 0x4 in cycle 3, IDLE in cycle 5.
- STAT=0x08 for 3 polls then 0x00: byte 0x55 written exactly once after the 4th poll; tx_ready pulses once only.
- rx_en=1, STAT=0x01, RX_FIFO=0x7E, rx_ready held low 10 cycles: rx_valid held with 0x7E, no further AR issued until rx_ready.
- tx_valid and rx_en both constantly high, status always ready: grants alternate TX, RX, TX, RX.
- bresp=2'b10 on a TX write: err=1 and stays set; a following transfer still completes. rst asserted during TX_AW: valids low the next cycle, INIT write reissued.
